// File: rtl/artec_dma_ch_sched.sv
// Burst scheduler: splits per-channel DMA transfers into <=MAX_BURST, 4 KB-safe bursts, round-robin arbitrated.
// Latency: start-to-cmd_valid 3 cycles from idle (IDLE -> ARB -> CMD); one burst outstanding at a time.
// Backpressure: cmd_* held stable while cmd_ready_i is low; the burst completes only on the datapath's beat_i pulses.

package artec_dma_pkg;
  localparam int PKG_CH_NUM = 4;
endpackage

module artec_dma_ch_sched #(
  parameter int CH_NUM     = artec_dma_pkg::PKG_CH_NUM,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 16,
  parameter int BEAT_BYTES = 8,
  parameter int MAX_BURST  = 16,
  localparam int CH_W      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
  localparam int BL_W      = $clog2(MAX_BURST) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic [CH_NUM-1:0]        ch_start_i,
  input  logic [CH_NUM*ADDR_W-1:0] ch_addr_i,
  input  logic [CH_NUM*LEN_W-1:0]  ch_len_i,
  output logic [CH_NUM-1:0]        ch_busy_o,
  output logic [CH_NUM-1:0]        ch_done_o,
  output logic                     cmd_valid_o,
  input  logic                     cmd_ready_i,
  output logic [CH_W-1:0]          cmd_ch_o,
  output logic [ADDR_W-1:0]        cmd_addr_o,
  output logic [BL_W-1:0]          cmd_len_o,
  input  logic                     beat_i
);

  localparam int BB_SH = $clog2(BEAT_BYTES);
  // Wide enough for both the remaining length and the 4 KB room (up to 4096 beats).
  localparam int CW    = (LEN_W > 13) ? LEN_W : 13;

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_CMD, S_DATA} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q [CH_NUM];
  logic [LEN_W-1:0]  rem_q  [CH_NUM];
  logic [CH_NUM-1:0] busy_q;
  logic [CH_NUM-1:0] done_q;
  logic [CH_W-1:0]   rr_q;
  logic [BL_W-1:0]   cnt_q;

  logic [CH_W-1:0]   grant;
  logic              found;
  logic [12:0]       room_bytes;
  logic [CW-1:0]     lim;
  logic [CW-1:0]     rem_x;
  logic [BL_W-1:0]   blen;
  logic              burst_fin;

  // Round-robin pick: first busy channel at or after the rr pointer, wrapping.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (!found && busy_q[(int'(rr_q) + i) % CH_NUM]) begin
        found = 1'b1;
        grant = CH_W'((int'(rr_q) + i) % CH_NUM);
      end
    end
  end

  // Burst length for the granted channel: min(remaining, MAX_BURST, beats left in this 4 KB page).
  always_comb begin
    room_bytes = 13'h1000 - {1'b0, addr_q[grant][11:0]};
    lim        = CW'(room_bytes >> BB_SH);
    if (CW'(MAX_BURST) < lim) begin
      lim = CW'(MAX_BURST);
    end
    rem_x = CW'(rem_q[grant]);
    blen  = (rem_x < lim) ? BL_W'(rem_x) : BL_W'(lim);
  end

  // Last beat of the current burst is being accepted this cycle.
  always_comb begin
    burst_fin = (state == S_DATA) && beat_i && ((cnt_q + BL_W'(1)) == cmd_len_o);
  end

  // Scheduler FSM with registered command outputs.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state       <= S_IDLE;
      rr_q        <= '0;
      cnt_q       <= '0;
      cmd_valid_o <= 1'b0;
      cmd_ch_o    <= '0;
      cmd_addr_o  <= '0;
      cmd_len_o   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|busy_q) begin
            state <= S_ARB;
          end
        end
        S_ARB: begin
          cmd_ch_o    <= grant;
          cmd_addr_o  <= addr_q[grant];
          cmd_len_o   <= blen;
          cmd_valid_o <= 1'b1;
          state       <= S_CMD;
        end
        S_CMD: begin
          if (cmd_ready_i) begin
            cmd_valid_o <= 1'b0;
            cnt_q       <= '0;
            state       <= S_DATA;
          end
        end
        S_DATA: begin
          if (burst_fin) begin
            rr_q  <= (cmd_ch_o == CH_W'(CH_NUM - 1)) ? '0 : cmd_ch_o + CH_W'(1);
            state <= S_IDLE;
          end else if (beat_i) begin
            cnt_q <= cnt_q + BL_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Channel bank: start loads, burst-completion bookkeeping, and done pulses.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      busy_q <= '0;
      done_q <= '0;
      for (int c = 0; c < CH_NUM; c++) begin
        addr_q[c] <= '0;
        rem_q[c]  <= '0;
      end
    end else begin
      done_q <= '0;
      for (int c = 0; c < CH_NUM; c++) begin
        if (ch_start_i[c] && !busy_q[c]) begin
          if (ch_len_i[c*LEN_W +: LEN_W] != '0) begin
            addr_q[c] <= ch_addr_i[c*ADDR_W +: ADDR_W];
            rem_q[c]  <= ch_len_i[c*LEN_W +: LEN_W];
            busy_q[c] <= 1'b1;
          end else begin
            done_q[c] <= 1'b1;
          end
        end
      end
      // The granted channel is busy, so a start on it above was ignored: no conflict.
      if (burst_fin) begin
        addr_q[cmd_ch_o] <= addr_q[cmd_ch_o] + (ADDR_W'(cmd_len_o) << BB_SH);
        rem_q[cmd_ch_o]  <= rem_q[cmd_ch_o] - LEN_W'(cmd_len_o);
        if (rem_q[cmd_ch_o] == LEN_W'(cmd_len_o)) begin
          busy_q[cmd_ch_o] <= 1'b0;
          done_q[cmd_ch_o] <= 1'b1;
        end
      end
    end
  end

  assign ch_busy_o = busy_q;
  assign ch_done_o = done_q;

endmodule

// File: tb/tb_artec_dma_ch_sched.sv
// Bench for artec_dma_ch_sched: directed scenarios then randomized traffic against a transfer-level model.
// Latency: model checks every cycle, sampling 1 time unit after the rising edge.
// Backpressure: cmd_ready and beat are driven randomly; held commands are checked for stability.

module tb_artec_dma_ch_sched;
  localparam int CH = 4;
  localparam int AW = 32;
  localparam int LW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            clear;
  logic [CH-1:0]   ch_start;
  logic [CH*AW-1:0] ch_addr;
  logic [CH*LW-1:0] ch_len;
  logic [CH-1:0]   ch_busy_o;
  logic [CH-1:0]   ch_done_o;
  logic            cmd_valid_o;
  logic            cmd_ready;
  logic [1:0]      cmd_ch_o;
  logic [AW-1:0]   cmd_addr_o;
  logic [4:0]      cmd_len_o;
  logic            beat;

  artec_dma_ch_sched dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .ch_start_i  (ch_start),
    .ch_addr_i   (ch_addr),
    .ch_len_i    (ch_len),
    .ch_busy_o   (ch_busy_o),
    .ch_done_o   (ch_done_o),
    .cmd_valid_o (cmd_valid_o),
    .cmd_ready_i (cmd_ready),
    .cmd_ch_o    (cmd_ch_o),
    .cmd_addr_o  (cmd_addr_o),
    .cmd_len_o   (cmd_len_o),
    .beat_i      (beat)
  );

  always #5 clk = ~clk;

  // Transfer-level model: per-channel list of pending bursts {addr,len}.
  bit [CH-1:0]  m_busy;
  bit [CH-1:0]  snap;
  bit [CH-1:0]  exp_done;
  logic [47:0]  bq [CH][$];
  int           m_rr;
  bit           in_data;
  int           cur_ch, cur_len, beats;
  bit           prev_valid;
  int           held_ch, held_len;
  logic [31:0]  held_addr;
  int           log_ch[$];
  logic [31:0]  log_addr[$];
  int           log_len[$];
  int           vectors = 0;
  int           miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_ch(input int c, input logic [31:0] a, input int len);
    logic [31:0] aa;
    int l, room, b;
    bq[c].delete();
    aa = a;
    l  = len;
    while (l > 0) begin
      room = (4096 - int'(aa[11:0])) / 8;
      b = l;
      if (b > 16) b = 16;
      if (b > room) b = room;
      bq[c].push_back({aa, 16'(b)});
      aa = aa + 32'(b * 8);
      l  = l - b;
    end
  endtask

  function automatic int rr_pick(input bit [CH-1:0] b, input int rr);
    for (int i = 0; i < CH; i++) begin
      if (b[(rr + i) % CH]) return (rr + i) % CH;
    end
    return -1;
  endfunction

  task automatic set_start(input int c, input logic [31:0] a, input int l);
    ch_start[c] = 1'b1;
    ch_addr[c*AW +: AW] = a;
    ch_len[c*LW +: LW] = 16'(l);
  endtask

  task automatic tick();
    bit rs, hs;
    snap = m_busy;
    exp_done = '0;
    rs = rst | clear;
    hs = 1'b0;
    if (rs) begin
      m_busy = '0;
      for (int c = 0; c < CH; c++) bq[c].delete();
      m_rr = 0;
      in_data = 1'b0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (ch_start[c] && !m_busy[c]) begin
          if (ch_len[c*LW +: LW] == 16'd0) exp_done[c] = 1'b1;
          else begin
            m_busy[c] = 1'b1;
            load_ch(c, ch_addr[c*AW +: AW], int'(ch_len[c*LW +: LW]));
          end
        end
      end
      if (in_data && beat) begin
        beats++;
        if (beats == cur_len) begin
          if (bq[cur_ch].size() > 0) void'(bq[cur_ch].pop_front());
          m_rr = (cur_ch + 1) % CH;
          if (bq[cur_ch].size() == 0) begin
            m_busy[cur_ch] = 1'b0;
            exp_done[cur_ch] = 1'b1;
          end
          in_data = 1'b0;
        end
      end
      if (prev_valid && cmd_ready) begin
        hs = 1'b1;
        in_data = 1'b1;
        cur_ch = held_ch;
        cur_len = held_len;
        beats = 0;
        log_ch.push_back(int'(cmd_ch_o));
        log_addr.push_back(cmd_addr_o);
        log_len.push_back(int'(cmd_len_o));
      end
    end
    @(posedge clk);
    #1;
    chk("busy", ch_busy_o, m_busy);
    chk("done", ch_done_o, exp_done);
    if (rs) begin
      chk("rst_valid", cmd_valid_o, 0);
      chk("rst_cmd", {cmd_ch_o, cmd_addr_o, cmd_len_o}, 0);
    end else begin
      if (prev_valid && !hs) chk("valid_hold", cmd_valid_o, 1);
      if (cmd_valid_o && !prev_valid) begin
        int e;
        e = rr_pick(snap, m_rr);
        chk("grant", cmd_ch_o, e);
        if (e >= 0) begin
          held_ch   = e;
          held_addr = bq[e][0][47:16];
          held_len  = int'(bq[e][0][15:0]);
        end else begin
          held_ch   = 0;
          held_addr = '0;
          held_len  = 1;
        end
        chk("cmd_addr", cmd_addr_o, held_addr);
        chk("cmd_len", cmd_len_o, held_len);
      end else if (cmd_valid_o && prev_valid) begin
        chk("hold_ch", cmd_ch_o, held_ch);
        chk("hold_addr", cmd_addr_o, held_addr);
        chk("hold_len", cmd_len_o, held_len);
      end
      if (in_data) chk("valid_in_data", cmd_valid_o, 0);
    end
    prev_valid = cmd_valid_o;
  endtask

  task automatic run(input int maxc, input int beat_pct, input int rdy_pct);
    int n;
    n = 0;
    while ((|m_busy || in_data || prev_valid) && n < maxc) begin
      cmd_ready = ($urandom_range(99) < rdy_pct);
      beat = in_data ? ($urandom_range(99) < beat_pct) : ($urandom_range(99) < 15);
      tick();
      n++;
    end
    chk("drain_busy", ch_busy_o, 0);
    cmd_ready = 1'b0;
    beat = 1'b0;
  endtask

  task automatic chk_log(input string tag, input int i, input int c, input logic [31:0] a, input int l);
    if (i < log_ch.size())
      chk(tag, {8'(log_ch[i]), log_addr[i], 8'(log_len[i])}, {8'(c), a, 8'(l)});
    else
      chk(tag, log_ch.size(), i + 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    log_ch.delete();
    log_addr.delete();
    log_len.delete();
  endtask

  initial begin
    int lat;
    rst = 1'b1; clear = 1'b0; ch_start = '0; ch_addr = '0; ch_len = '0;
    cmd_ready = 1'b0; beat = 1'b0;
    m_busy = '0; m_rr = 0; in_data = 1'b0; prev_valid = 1'b0;
    cur_ch = 0; cur_len = 0; beats = 0; held_ch = 0; held_len = 0; held_addr = '0;
    do_reset();

    // 1: 40 beats from 0 -> 16,16,8; also start-to-valid latency
    set_start(0, 32'h0, 40);
    cmd_ready = 1'b1;
    tick();
    ch_start = '0;
    lat = 1;
    while (!cmd_valid_o && lat < 10) begin tick(); lat++; end
    chk("t1_latency", lat, 3);
    run(300, 100, 100);
    chk("t1_n", log_ch.size(), 3);
    chk_log("t1_b0", 0, 0, 32'h000, 16);
    chk_log("t1_b1", 1, 0, 32'h080, 16);
    chk_log("t1_b2", 2, 0, 32'h100, 8);

    // 2: 4 KB boundary split
    log_ch.delete(); log_addr.delete(); log_len.delete();
    set_start(0, 32'hFE0, 10);
    tick();
    ch_start = '0;
    run(300, 70, 70);
    chk("t2_n", log_ch.size(), 2);
    chk_log("t2_b0", 0, 0, 32'hFE0, 4);
    chk_log("t2_b1", 1, 0, 32'h1000, 6);

    // 3: four channels at once -> grant order 0,1,2,3,0,1,2,3
    do_reset();
    for (int c = 0; c < CH; c++) set_start(c, 32'(c) << 16, 32);
    tick();
    ch_start = '0;
    run(1000, 80, 80);
    chk("t3_n", log_ch.size(), 8);
    for (int i = 0; i < 8; i++) chk_log($sformatf("t3_b%0d", i), i, i % 4, (32'(i % 4) << 16) + 32'((i / 4) * 128), 16);

    // 4: cmd_ready low for 5 cycles while valid
    log_ch.delete(); log_addr.delete(); log_len.delete();
    set_start(3, 32'h40, 5);
    cmd_ready = 1'b0;
    tick();
    ch_start = '0;
    lat = 0;
    while (!cmd_valid_o && lat < 10) begin tick(); lat++; end
    chk("t4_valid", cmd_valid_o, 1);
    for (int i = 0; i < 5; i++) tick();
    run(200, 100, 100);
    chk("t4_n", log_ch.size(), 1);
    chk_log("t4_b0", 0, 3, 32'h40, 5);

    // 5: zero-length start and restart of a busy channel
    log_ch.delete(); log_addr.delete(); log_len.delete();
    set_start(2, 32'h200, 20);
    cmd_ready = 1'b1;
    tick();
    ch_start = '0;
    set_start(1, 32'h0, 0);
    set_start(2, 32'h999000, 3);
    tick();
    ch_start = '0;
    chk("t5_done1", ch_done_o[1], 1);
    run(300, 100, 100);
    chk("t5_n", log_ch.size(), 2);
    chk_log("t5_b0", 0, 2, 32'h200, 16);
    chk_log("t5_b1", 1, 2, 32'h280, 4);

    // 6: clear mid-DATA after 3 beats; rr pointer returns to 0
    log_ch.delete(); log_addr.delete(); log_len.delete();
    set_start(0, 32'h0, 32);
    cmd_ready = 1'b1;
    tick();
    ch_start = '0;
    lat = 0;
    while (!in_data && lat < 10) begin tick(); lat++; end
    cmd_ready = 1'b0;
    beat = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    beat = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t6_busy", ch_busy_o, 0);
    chk("t6_valid", cmd_valid_o, 0);
    beat = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    beat = 1'b0;
    chk("t6_n", log_ch.size(), 1);
    set_start(1, 32'h1000, 4);
    set_start(3, 32'h3000, 4);
    tick();
    ch_start = '0;
    run(300, 100, 100);
    chk_log("t6_b1", 1, 1, 32'h1000, 4);
    chk_log("t6_b2", 2, 3, 32'h3000, 4);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      ch_start = '0;
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(99) < 5) begin
          logic [31:0] a;
          case ($urandom_range(2))
            0: a = $urandom & 32'hFFFF_FFF8;
            1: a = ($urandom & 32'hFFFF_F000) | 32'(12'hF00 + 12'($urandom_range(31) * 8));
            default: a = 32'hFFFF_FF80 + 32'($urandom_range(15) * 8);
          endcase
          set_start(c, a, $urandom_range(40));
        end
      end
      clear = ($urandom_range(999) < 3);
      cmd_ready = ($urandom_range(99) < 60);
      beat = in_data ? ($urandom_range(99) < 70) : ($urandom_range(99) < 15);
      tick();
    end
    ch_start = '0;
    clear = 1'b0;
    run(4000, 100, 100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
